roulette_spinner: RTL and testbench
===================================

Name: roulette_spinner

Overview:
- Responder for the game controller's spin handshake. It accepts a one-cycle `start_spin` pulse, then steps a one-hot lamp ring of 8 LEDs around the wheel.
- The ring runs at constant speed for a fixed number of laps, then slows down and stops on a pseudo-random target.
- On stopping it returns `spin_done` (one-cycle pulse) and `roulette_pos` (0..7) to the controller.
- Sits between the FSM controller and the board LED pins.

Parameters:
- BASE_DIV, 16'd50000, clock cycles per step during the fast phase (must be ≥2).
- DECEL, 16'd25000, amount added to the step period after each slow-phase step.
- LAPS, 3'd3, number of full 8-step laps before the target offset (1..7).
- SLOW_STEPS, 6'd6, number of final steps that run in the slow phase (1..8).
- BLINK_DIV, 16'd50000, half-period in cycles of the result blink (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start_spin  in  1  one-cycle spin request from the controller.
- force_valid  in  1  when high at start, the stop target is taken from force_target (test/debug use).
- force_target  in  3  forced stop position.
- busy  out  1  high while a spin is in progress.
- spin_done  out  1  one-cycle pulse: spin finished and roulette_pos is valid.
- roulette_pos  out  3  current lamp position, 0..7.
- led  out  8  one-hot lamp drive, equal to 1<<roulette_pos (except during blink).

Behaviour:
- Reset values:
  - state=IDLE; roulette_pos=0; led=8'h01; busy=0; spin_done=0.
  - div_cnt=0; period=BASE_DIV; steps_left=0.
  - lfsr=16'hACE1.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every cycle in every state; must never reach 0.
- States: IDLE, RUN, BLINK (BLINK exists only with the optional feature).
- IDLE:
  - start_spin=1 captures target = force_valid ? force_target : lfsr[2:0].
  - Loads steps_left = 8*LAPS + ((target - roulette_pos) mod 8). Width is 6 bits, maximum 63.
  - Sets div_cnt=0, period=BASE_DIV, busy=1, state=RUN. All of this happens on the same edge.
- RUN:
  - div_cnt increments every cycle.
  - When div_cnt==period-1, on that edge:
    - div_cnt resets to 0.
    - roulette_pos advances by 1, wrapping 7→0.
    - led follows roulette_pos.
    - steps_left decrements.
    - If steps_left (pre-decrement) ≤ SLOW_STEPS, period += DECEL, saturating at 16'hFFFF.
    - If steps_left (pre-decrement) == 1, this was the final step:
      - spin_done=1 for exactly one cycle on the same edge, busy=0, state=IDLE (feature off).
      - With the feature on, state=BLINK instead.
- Step periods: fast steps each take BASE_DIV cycles. The last SLOW_STEPS steps take BASE_DIV, BASE_DIV+DECEL, BASE_DIV+2·DECEL, and so on.
- Position at stop:
  - The final roulette_pos equals target.
  - roulette_pos is held stable until the next start.
- Boundary and corner cases:
  - start_spin while busy: ignored; no restart and no retarget.
  - start_spin in the same cycle as the spin_done edge: the FSM is not yet in IDLE, so the request is ignored.
  - target == roulette_pos: offset is 0, so exactly 8*LAPS steps.
  - force_valid or force_target changing mid-spin: no effect.
  - rst mid-spin: immediately returns to the reset values; no spin_done is emitted.

Optional Feature:
- Macro: ROULETTE_BLINK_EN.
- Defined:
  - After the final step, the FSM enters BLINK with busy held at 1.
  - led alternates between 0 and 1<<roulette_pos every BLINK_DIV cycles, for 6 half-periods. The first half-period is off.
  - Then led = 1<<roulette_pos, and spin_done pulses for one cycle with busy=0 on the same edge, returning to IDLE.
  - Added latency: 6·BLINK_DIV cycles.
- Undefined: the BLINK state and the blink counter are absent; spin_done coincides with the final step edge.

Test Plan:
Parameters for all scenarios: BASE_DIV=4, DECEL=2, LAPS=2, SLOW_STEPS=4, BLINK_DIV=3; feature off unless stated.
1. Reset, then force_valid=1, force_target=3, start_spin pulse at edge E0 → 19 steps.
   - roulette_pos changes at E4, E8, … E60 (15 fast steps), then at E64, E70, E78, E88.
   - spin_done is high only in the cycle after E88; roulette_pos=3, led=8'h08, busy low from E88.
2. From pos 3, force target 3 → exactly 16 steps; total 12·4+4+6+8+10 = 76 cycles; ends at pos 3.
3. start_spin re-pulsed at E20 during scenario 1 → timing and target unchanged, single spin_done.
4. rst asserted at E30 mid-spin → immediately pos=0, led=8'h01, busy=0; no spin_done appears over the next 200 cycles.
5. force_valid=0, 50 back-to-back spins → each stop position equals the lfsr[2:0] sampled at its start edge; LFSR never 0.
6. Feature on (ROULETTE_BLINK_EN), scenario 1 stimulus:
   - led=0 for E88–E91, 8'h08 for E91–E94, alternating through 6 half-periods.
   - spin_done pulses at E106 with led=8'h08.

Source files
------------

// File: rtl/roulette_spinner.sv
// Roulette lamp spinner: steps a one-hot ring of 8 LEDs, decelerates, and stops on a target.
// Optional result blink before spin_done is enabled by defining ROULETTE_BLINK_EN.
module roulette_spinner #(
  parameter logic [15:0] BASE_DIV   = 16'd50000,
  parameter logic [15:0] DECEL      = 16'd25000,
  parameter logic [2:0]  LAPS       = 3'd3,
  parameter logic [5:0]  SLOW_STEPS = 6'd6,
  parameter logic [15:0] BLINK_DIV  = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_spin,
  input  logic       force_valid,
  input  logic [2:0] force_target,
  output logic       busy,
  output logic       spin_done,
  output logic [2:0] roulette_pos,
  output logic [7:0] led
);

  if (BASE_DIV < 16'd2 || LAPS == 3'd0 || SLOW_STEPS == 6'd0 || SLOW_STEPS > 6'd8 ||
      BLINK_DIV == 16'd0) begin : g_bad_param
    $error("roulette_spinner: parameter out of range");
  end

`ifdef ROULETTE_BLINK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BLINK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic [2:0]  pos_q, pos_d;
  logic [7:0]  led_q, led_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [15:0] period_q, period_d;
  logic [5:0]  steps_q, steps_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  target;
`ifdef ROULETTE_BLINK_EN
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic [2:0]  half_q, half_d;
`endif

  function automatic logic [7:0] onehot(input logic [2:0] p);
    return 8'd1 << p;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign target = force_valid ? force_target : lfsr_q[2:0];

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    led_d     = led_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    div_cnt_d = div_cnt_q;
    period_d  = period_q;
    steps_d   = steps_q;
    // x^16+x^14+x^13+x^11+1, left-shifting Fibonacci form
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`ifdef ROULETTE_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    half_d      = half_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_spin) begin
          steps_d   = {LAPS, 3'b000} + {3'b000, target - pos_q};
          div_cnt_d = 16'd0;
          period_d  = BASE_DIV;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        div_cnt_d = div_cnt_q + 16'd1;
        if (div_cnt_q == period_q - 16'd1) begin
          div_cnt_d = 16'd0;
          pos_d     = pos_q + 3'd1;
          led_d     = onehot(pos_q + 3'd1);
          steps_d   = steps_q - 6'd1;
          if (steps_q <= SLOW_STEPS) period_d = sat_add(period_q, DECEL);
          if (steps_q == 6'd1) begin
`ifdef ROULETTE_BLINK_EN
            // Result blink starts with the lamp dark for one half-period.
            led_d       = 8'h00;
            blink_cnt_d = 16'd0;
            half_d      = 3'd0;
            state_d     = BLINK;
`else
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef ROULETTE_BLINK_EN
      BLINK: begin
        blink_cnt_d = blink_cnt_q + 16'd1;
        if (blink_cnt_q == BLINK_DIV - 16'd1) begin
          blink_cnt_d = 16'd0;
          if (half_q == 3'd5) begin
            led_d   = onehot(pos_q);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            half_d = half_q + 3'd1;
            led_d  = half_q[0] ? 8'h00 : onehot(pos_q);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pos_q     <= 3'd0;
      led_q     <= 8'h01;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div_cnt_q <= 16'd0;
      period_q  <= BASE_DIV;
      steps_q   <= 6'd0;
      lfsr_q    <= 16'hACE1;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div_cnt_q <= div_cnt_d;
      period_q  <= period_d;
      steps_q   <= steps_d;
      lfsr_q    <= lfsr_d;
    end
  end

`ifdef ROULETTE_BLINK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= 16'd0;
      half_q      <= 3'd0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      half_q      <= half_d;
    end
  end
`endif

  assign busy         = busy_q;
  assign spin_done    = done_q;
  assign roulette_pos = pos_q;
  assign led          = led_q;

endmodule

// File: tb/tb_roulette_spinner.sv
// Bench for roulette_spinner: table of forced spins, scoreboard of stop position/latency,
// plus hand-written sequences for restart, done-edge start, mid-spin reset and random targets.
module tb_roulette_spinner;

`ifdef ROULETTE_BLINK_EN
  localparam int EXTRA = 18;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_spin = 1'b0;
  logic       force_valid = 1'b0;
  logic [2:0] force_target = 3'd0;
  logic       busy;
  logic       spin_done;
  logic [2:0] roulette_pos;
  logic [7:0] led;

  roulette_spinner #(
    .BASE_DIV(16'd4), .DECEL(16'd2), .LAPS(3'd2), .SLOW_STEPS(6'd4), .BLINK_DIV(16'd3)
  ) dut (
    .clk(clk), .rst(rst), .start_spin(start_spin), .force_valid(force_valid),
    .force_target(force_target), .busy(busy), .spin_done(spin_done),
    .roulette_pos(roulette_pos), .led(led)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, seed ACE1, shifting left every cycle.
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef struct { int pos; int cycles; } exp_t;
  typedef struct { logic [2:0] tgt; int cycles; } vec_t;

  exp_t sb[$];
  int   chg[$];
  int   led_hist[0:511];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_pos = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start_spin = 1'b0; force_valid = 1'b0; force_target = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cur_pos = 0;
  endtask

  // exp_cyc < 0: derive latency from the target; poke_at > 0: also hold start_spin at that edge.
  task automatic spin(input bit fv, input logic [2:0] ft, input int exp_cyc,
                      input int poke_at, input string tag);
    exp_t e;
    exp_t got;
    int   n;
    bit   seen;
    logic [2:0] prev;
    @(negedge clk);
    e.pos    = fv ? int'(ft) : int'(m_lfsr[2:0]);
    e.cycles = (exp_cyc >= 0) ? exp_cyc
             : 4 * (16 + ((e.pos - cur_pos + 8) % 8)) + 12 + EXTRA;
    sb.push_back(e);
    force_valid = fv; force_target = ft; start_spin = 1'b1;
    @(negedge clk);
    start_spin = 1'b0;
    force_valid = 1'($urandom);
    force_target = 3'($urandom);
    check({tag, "_busy_start"}, int'(busy), 1);
    chg.delete();
    prev = roulette_pos;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 400) begin
      n++;
      @(negedge clk);
      start_spin = (n == poke_at - 1);
      led_hist[n] = int'(led);
      if (roulette_pos != prev) begin
        chg.push_back(n);
        prev = roulette_pos;
      end
      if (spin_done) seen = 1'b1;
    end
    start_spin = 1'b0;
    got = sb.pop_front();
    cur_pos = got.pos;
    if (!seen) begin
      check({tag, "_done_timeout"}, n, got.cycles);
    end else begin
      check({tag, "_latency"}, n, got.cycles);
      check({tag, "_pos"}, int'(roulette_pos), got.pos);
      check({tag, "_led"}, int'(led), 1 << got.pos);
      check({tag, "_busy_done"}, int'(busy), 0);
      @(negedge clk);
      check({tag, "_done_pulse"}, int'(spin_done), 0);
    end
  endtask

  vec_t tbl[7];
  int   exp_edges[$];
  int   cnt;

  initial begin
    // forced target, latency from E0 to spin_done (4*steps+12)
    tbl[0] = '{3'd3, 88};
    tbl[1] = '{3'd3, 76};
    tbl[2] = '{3'd0, 96};
    tbl[3] = '{3'd7, 104};
    tbl[4] = '{3'd6, 104};
    tbl[5] = '{3'd6, 76};
    tbl[6] = '{3'd1, 88};
    for (int k = 1; k <= 15; k++) exp_edges.push_back(4 * k);
    exp_edges.push_back(64); exp_edges.push_back(70);
    exp_edges.push_back(78); exp_edges.push_back(88);

    do_reset();
    check("rst_pos", int'(roulette_pos), 0);
    check("rst_led", int'(led), 8'h01);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(spin_done), 0);

    for (int i = 0; i < 7; i++) begin
      spin(1'b1, tbl[i].tgt, tbl[i].cycles + EXTRA, 0, $sformatf("tbl%0d", i));
      if (i == 0) begin
        check("s1_edge_count", chg.size(), exp_edges.size());
        for (int k = 0; k < exp_edges.size() && k < chg.size(); k++)
          check($sformatf("s1_edge%0d", k), chg[k], exp_edges[k]);
        check("s1_led_at60", led_hist[60], 8'h80);
`ifdef ROULETTE_BLINK_EN
        check("blink_off_89", led_hist[89], 8'h00);
        check("blink_on_92", led_hist[92], 8'h08);
        check("blink_off_95", led_hist[95], 8'h00);
        check("blink_on_104", led_hist[104], 8'h08);
`else
        check("s1_led_at88", led_hist[88], 8'h08);
`endif
      end
    end

    // restart request mid-spin is ignored
    do_reset();
    spin(1'b1, 3'd3, 88 + EXTRA, 20, "repulse");
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (spin_done) cnt++;
    end
    check("repulse_extra_done", cnt, 0);

    // start on the spin_done edge is ignored
    spin(1'b1, 3'd3, 76 + EXTRA, 76 + EXTRA, "done_edge");
    check("done_edge_busy", int'(busy), 0);
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (spin_done || busy) cnt++;
    end
    check("done_edge_no_restart", cnt, 0);

    // asynchronous reset mid-spin
    do_reset();
    @(negedge clk);
    force_valid = 1'b1; force_target = 3'd5; start_spin = 1'b1;
    @(negedge clk);
    start_spin = 1'b0;
    repeat (29) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_pos", int'(roulette_pos), 0);
    check("midrst_led", int'(led), 8'h01);
    check("midrst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur_pos = 0;
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (spin_done || busy || roulette_pos != 3'd0) cnt++;
    end
    check("midrst_quiet", cnt, 0);

    // LFSR-chosen targets, back to back
    for (int i = 0; i < 50; i++) spin(1'b0, 3'd0, -1, 0, $sformatf("rnd%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
